// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter for synchronized four-phase requests: one grant strobe
// per decision to a shared destination, level ACK returned to each requester.
module sync_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_SYNC,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic                          DST_BUSY,
    output logic                          GNT_VLD,
    output logic [ID_WIDTH-1:0]           GNT_ID,
    output logic [DATA_WIDTH-1:0]         GNT_DATA,
    output logic [NUM_REQ-1:0]            ACK
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [ID_WIDTH-1:0]     last_reg, last_next;
    logic [NUM_REQ-1:0]      ack_reg, ack_next;
    logic                    gnt_vld_reg, gnt_vld_next;
    logic [ID_WIDTH-1:0]     gnt_id_reg, gnt_id_next;
    logic [DATA_WIDTH-1:0]   gnt_data_reg, gnt_data_next;

    logic [NUM_REQ-1:0]      eligible;
    logic [NUM_REQ-1:0]      upper_mask;
    logic [NUM_REQ-1:0]      upper_elig;
    logic [NUM_REQ-1:0]      pick_src;
    logic                    any_upper;
    logic                    any_elig;
    logic                    grant;
    logic [ID_WIDTH-1:0]     win_id;
    logic [DATA_WIDTH-1:0]   win_data;

    // Per-requester eligibility, round-robin mask and ACK handshake.
    // Indices above LAST are searched first; if none qualifies the lowest
    // eligible index wins, which wraps modulo NUM_REQ without arithmetic.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign eligible[gi]   = REQ_SYNC[gi] & ~ack_reg[gi];
            assign upper_mask[gi] = (ID_WIDTH'(gi) > last_reg);
            assign upper_elig[gi] = eligible[gi] & upper_mask[gi];
            assign ack_next[gi]   = (grant && (win_id == ID_WIDTH'(gi)))
                                  | (ack_reg[gi] & REQ_SYNC[gi]);
        end
    endgenerate

    assign any_upper = |upper_elig;
    assign any_elig  = |eligible;
    assign pick_src  = any_upper ? upper_elig : eligible;

    // Lowest set bit of the chosen candidate vector is the winner.
    always_comb begin
        win_id   = '0;
        win_data = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick_src[i]) begin
                win_id   = ID_WIDTH'(i);
                win_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        gnt_vld_next  = 1'b0;
        gnt_id_next   = gnt_id_reg;
        gnt_data_next = gnt_data_reg;
        grant         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!DST_BUSY && any_elig) begin
                    grant         = 1'b1;
                    gnt_vld_next  = 1'b1;
                    gnt_id_next   = win_id;
                    gnt_data_next = win_data;
                    last_next     = win_id;
                    state_next    = ISSUE;
                end
            end
            ISSUE:   state_next = GAP;
            // GAP gives the destination a cycle to raise DST_BUSY.
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg    <= IDLE;
            last_reg     <= ID_WIDTH'(NUM_REQ - 1);
            ack_reg      <= '0;
            gnt_vld_reg  <= 1'b0;
            gnt_id_reg   <= '0;
            gnt_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            ack_reg      <= ack_next;
            gnt_vld_reg  <= gnt_vld_next;
            gnt_id_reg   <= gnt_id_next;
            gnt_data_reg <= gnt_data_next;
        end
    end

    assign GNT_VLD  = gnt_vld_reg;
    assign GNT_ID   = gnt_id_reg;
    assign GNT_DATA = gnt_data_reg;
    assign ACK      = ack_reg;

endmodule

// File: doc/sync_req_arbiter.md
# sync_req_arbiter

Round-robin scheduler that shares one destination resource between several requesters in foreign clock domains. Each requester drives a four-phase request level that is synchronized into this block's domain upstream by a bit synchronizer; this block picks one eligible request at a time, issues a one-cycle grant with the requester's data to the destination, and returns a level acknowledge that crosses back to the requester. Single clock domain; sits directly behind the per-requester synchronizer bank.

## Interface
- NUM_REQ, 4, number of requesters, legal range 2..16
- DATA_WIDTH, 8, payload width per requester
- ID_WIDTH, $clog2(NUM_REQ), grant index width (derived, not overridden)
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  reset, synchronous, active-low
- REQ_SYNC  input  NUM_REQ  synchronized request levels, bit i per requester
- REQ_DATA  input  NUM_REQ*DATA_WIDTH  payload, slice i = bits [i*DATA_WIDTH +: DATA_WIDTH], stable while REQ_SYNC[i]=1
- DST_BUSY  input  1  destination cannot accept a grant
- GNT_VLD  output  1  one-cycle grant strobe to destination
- GNT_ID  output  ID_WIDTH  index of granted requester, valid with GNT_VLD
- GNT_DATA  output  DATA_WIDTH  registered copy of granted payload, valid with GNT_VLD
- ACK  output  NUM_REQ  acknowledge levels, one per requester, registered

## Operation
- Eligible(i) = REQ_SYNC[i] & ~ACK[i]. A request held high after its ACK is never granted twice.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: if DST_BUSY=0 and any eligible -> pick winner, register GNT_ID/GNT_DATA, set GNT_VLD=1, set ACK[winner]=1, update pointer, go ISSUE. Otherwise stay, GNT_VLD=0.
  - ISSUE: GNT_VLD=0, go GAP unconditionally.
  - GAP: go IDLE unconditionally (one cycle for destination to raise DST_BUSY).
- Arbitration: round-robin pointer LAST (ID_WIDTH bits) holds last winner; search order LAST+1, LAST+2, ... wrapping modulo NUM_REQ; first eligible wins. LAST <= winner on grant. Wrap is modulo NUM_REQ, not 2^ID_WIDTH (NUM_REQ non-power-of-2 supported).
- ACK[i] set: only on grant to i. ACK[i] clear: on the edge after REQ_SYNC[i] sampled 0 while ACK[i]=1, independent of FSM state. Set and clear for same i never coincide (set requires REQ_SYNC[i]=1).
- REQ_SYNC[i] dropping while ACK[i]=0 (requester withdrawal): no grant to i, no error.
- GNT_ID/GNT_DATA hold last granted values between grants; only GNT_VLD qualifies them.
- DST_BUSY sampled only in IDLE; DST_BUSY changes in ISSUE/GAP are ignored.

## Timing
- Reset (RST=0 at a rising edge): state=IDLE, GNT_VLD=0, GNT_ID=0, GNT_DATA=0, ACK=0, LAST=NUM_REQ-1 (requester 0 has first priority). Reset overrides all other activity, including mid-ISSUE/GAP; a request still high after reset is eligible again and re-granted.
- Grant latency: eligible request and DST_BUSY=0 sampled at edge N -> GNT_VLD=1 and ACK[i]=1 from edge N (visible cycle N..N+1), GNT_VLD=0 at edge N+1.
- Minimum grant spacing: 3 cycles (IDLE->ISSUE->GAP->IDLE); sustained throughput 1 grant / 3 cycles.
- ACK clear latency: 1 cycle after REQ_SYNC[i] low is sampled.
- Simultaneous requests: one winner per IDLE decision; others wait, keep ACK=0.

## Test plan
- Reset: drive RST=0 with REQ_SYNC=4'b1111 -> GNT_VLD=0, ACK=0, GNT_ID=0, GNT_DATA=0; release RST -> first grant GNT_ID=0 one cycle later.
- Single requester: REQ_SYNC[2]=1, slice 2=8'hA5, DST_BUSY=0 -> GNT_VLD pulse 1 cycle, GNT_ID=2, GNT_DATA=8'hA5, ACK[2]=1; keep REQ high 20 cycles -> no second grant; drop REQ -> ACK[2]=0 next cycle.
- Round-robin: REQ_SYNC=4'b1111 continuously, each requester drops REQ 2 cycles after its ACK and re-raises after ACK low -> grant order 0,1,2,3,0,1,..., grants exactly 3 cycles apart when saturated.
- Backpressure: DST_BUSY=1 with REQ_SYNC=4'b0110 for 10 cycles -> no GNT_VLD, ACK=0; DST_BUSY=0 -> GNT_ID=1 first, then 2.
- Wrap with NUM_REQ=3: LAST=2, REQ_SYNC=3'b011 -> GNT_ID=0 (not invalid index 3), then GNT_ID=1.
- Reset mid-operation: assert RST=0 during ISSUE with ACK[1]=1 -> all outputs 0 next edge; REQ_SYNC[1] still high after release -> re-granted GNT_ID=1.
